// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
//   Shared definitions for the CNN front-end blocks.
//   - WI_DEF   : default pixel width (signed pixels)
//   - state_e  : sequencer state encoding (IDLE=0, RUN=1, FLUSH=2, DONE=3)
//   - clog2    : counter-width helper, never returns less than one bit
//   - pack_win : assembles one {left, mid, right} window row, left in the MSBs
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int WI_DEF = 8;
    // Widest pixel pack_win can carry; narrower pixels sit in the low bits.
    localparam int WI_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Ceiling log2 with a floor of 1 so that degenerate sizes still get a
    // legal one-bit counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Packs three pixels of width wi into one window row with left in the
    // MSBs. The caller keeps the low 3*wi bits of the result.
    function automatic logic [3*WI_MAX-1:0] pack_win(
        input logic [WI_MAX-1:0] left,
        input logic [WI_MAX-1:0] mid,
        input logic [WI_MAX-1:0] right,
        input int                wi
    );
        logic [3*WI_MAX-1:0] row;
        row = '0;
        for (int i = 0; i < WI_MAX; i++) begin
            if (i < wi) begin
                row[2*wi + i] = left[i];
                row[wi + i]   = mid[i];
                row[i]        = right[i];
            end
        end
        return row;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// -----------------------------------------------------------------------------
// conv_line_buffer
//   Two-line pixel store for the 3x3 window generator. Line A holds row r-2,
//   line B holds row r-1 for the column currently being addressed.
//   Read is asynchronous and the write lands on the clock edge, so a read
//   and write of the same column in one cycle returns the old contents.
// Ports
//   iClk   in   clock
//   iWe    in   write enable: shift column iAddr down (B->A, iPix->B)
//   iAddr  in   column address
//   iPix   in   new pixel for line B
//   oTop   out  line A at iAddr (row r-2)
//   oMid   out  line B at iAddr (row r-1)
// -----------------------------------------------------------------------------
module conv_line_buffer
    import cnn_pkg::*;
#(
    parameter int WI    = WI_DEF,
    parameter int DEPTH = 28,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic                 iClk,
    input  logic                 iWe,
    input  logic [AW-1:0]        iAddr,
    input  logic signed [WI-1:0] iPix,
    output logic signed [WI-1:0] oTop,
    output logic signed [WI-1:0] oMid
);

    logic [WI-1:0] mem_a [DEPTH];
    logic [WI-1:0] mem_b [DEPTH];

    assign oTop = mem_a[iAddr];
    assign oMid = mem_b[iAddr];

    // NOTE: the arrays have no reset: their contents are never observed until
    // the row counter proves two full lines were written, and leaving reset
    // off lets them map onto RAM. Non-blocking writes keep the B->A move
    // reading the pre-edge value of B.
    always_ff @(posedge iClk) begin
        if (iWe) begin
            mem_a[iAddr] <= mem_b[iAddr];
            mem_b[iAddr] <= iPix;
        end
    end

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// -----------------------------------------------------------------------------
// conv3x3_window_ctrl
//   Frame sequencer and 3x3 window generator in front of the convolution
//   datapath. Accepts one IMG_W x IMG_H raster per iStart, emits every
//   fully-populated 3x3 window (no padding), waits CONV_LAT+1 cycles for the
//   downstream pipeline to drain, then pulses oDone.
// Ports
//   iClk, iRst         clock, synchronous active-high reset
//   iStart             start-of-frame pulse, honoured only in IDLE
//   iPixValid/iPixData input pixel stream, accepted when oPixReady is high
//   oPixReady          high while in RUN
//   oWinValid          registered window strobe
//   oWinRow1..3        window rows {c-2, c-1, c}, left in MSBs; Row3 is newest
//   oBusy              state != IDLE
//   oDone              one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module conv3x3_window_ctrl
    import cnn_pkg::*;
#(
    parameter int WI       = WI_DEF,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int CONV_LAT = 1
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic                 iPixValid,
    input  logic signed [WI-1:0] iPixData,
    output logic                 oPixReady,
    output logic                 oWinValid,
    output logic [3*WI-1:0]      oWinRow1,
    output logic [3*WI-1:0]      oWinRow2,
    output logic [3*WI-1:0]      oWinRow3,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int CW = clog2(IMG_W);
    localparam int RW = clog2(IMG_H);
    localparam int FW = clog2(CONV_LAT + 1);

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [FW-1:0]   flush_q, flush_d;
    logic            win_valid_q, win_valid_d;
    logic [3*WI-1:0] win_row1_q, win_row1_d;
    logic [3*WI-1:0] win_row2_q, win_row2_d;
    logic [3*WI-1:0] win_row3_q, win_row3_d;

    logic                 accept;
    logic signed [WI-1:0] lb_top;
    logic signed [WI-1:0] lb_mid;

    assign accept = iPixValid && (state_q == ST_RUN);

    conv_line_buffer #(
        .WI    (WI),
        .DEPTH (IMG_W)
    ) u_line_buffer (
        .iClk  (iClk),
        .iWe   (accept),
        .iAddr (col_q),
        .iPix  (iPixData),
        .oTop  (lb_top),
        .oMid  (lb_mid)
    );

    always_comb begin
        // NOTE: every target gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        flush_d     = flush_q;
        win_valid_d = 1'b0;
        win_row1_d  = win_row1_q;
        win_row2_d  = win_row2_q;
        win_row3_d  = win_row3_q;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    // Column shift registers: oldest column drops out of the MSBs.
                    // The c>=2 gate below keeps stale columns from the previous
                    // row out of any emitted window, so no flush at row wrap.
                    win_row1_d  = {win_row1_q[2*WI-1:0], lb_top};
                    win_row2_d  = {win_row2_q[2*WI-1:0], lb_mid};
                    win_row3_d  = {win_row3_q[2*WI-1:0], iPixData};
                    win_valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d = '0;
                        if (row_q == RW'(IMG_H - 1)) begin
                            state_d = ST_FLUSH;
                            flush_d = '0;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                // Holds CONV_LAT+1 cycles: counts 0..CONV_LAT.
                if (flush_q == FW'(CONV_LAT)) begin
                    state_d = ST_DONE;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            flush_q     <= '0;
            win_valid_q <= 1'b0;
            win_row1_q  <= '0;
            win_row2_q  <= '0;
            win_row3_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            flush_q     <= flush_d;
            win_valid_q <= win_valid_d;
            win_row1_q  <= win_row1_d;
            win_row2_q  <= win_row2_d;
            win_row3_q  <= win_row3_d;
        end
    end

    assign oPixReady = (state_q == ST_RUN);
    assign oBusy     = (state_q != ST_IDLE);
    assign oDone     = (state_q == ST_DONE);
    assign oWinValid = win_valid_q;
    assign oWinRow1  = win_row1_q;
    assign oWinRow2  = win_row2_q;
    assign oWinRow3  = win_row3_q;

endmodule

// File: tb/tb_conv3x3_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv3x3_window_ctrl
//   Scoreboard bench for a 5x5 frame with CONV_LAT=1. The driver pushes the
//   expected window for every accepted pixel at (r>=2, c>=2); the monitor pops
//   and compares on each oWinValid.
// -----------------------------------------------------------------------------
module tb_conv3x3_window_ctrl;

    localparam int WI  = 8;
    localparam int W   = 5;
    localparam int H   = 5;
    localparam int LAT = 1;
    localparam int N   = W * H;

    typedef struct packed {
        logic [3*WI-1:0] r1;
        logic [3*WI-1:0] r2;
        logic [3*WI-1:0] r3;
    } win_t;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 pv;
    logic signed [WI-1:0] pd;
    logic                 pix_ready;
    logic                 win_valid;
    logic [3*WI-1:0]      win_row1;
    logic [3*WI-1:0]      win_row2;
    logic [3*WI-1:0]      win_row3;
    logic                 busy;
    logic                 done;

    int   n_tests  = 0;
    int   n_fail   = 0;
    int   win_cnt  = 0;
    int   done_cnt = 0;
    win_t sb [$];
    win_t mon_w;
    logic [WI-1:0] img [N];

    conv3x3_window_ctrl #(
        .WI       (WI),
        .IMG_W    (W),
        .IMG_H    (H),
        .CONV_LAT (LAT)
    ) dut (
        .iClk      (clk),
        .iRst      (rst),
        .iStart    (start),
        .iPixValid (pv),
        .iPixData  (pd),
        .oPixReady (pix_ready),
        .oWinValid (win_valid),
        .oWinRow1  (win_row1),
        .oWinRow2  (win_row2),
        .oWinRow3  (win_row3),
        .oBusy     (busy),
        .oDone     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare every window against the scoreboard head.
    always @(negedge clk) begin
        if (win_valid === 1'b1) begin
            win_cnt++;
            if (sb.size() == 0) begin
                check("unexpected window", 32'd1, 32'd0);
            end else begin
                mon_w = sb.pop_front();
                check("row1", win_row1, mon_w.r1);
                check("row2", win_row2, mon_w.r2);
                check("row3", win_row3, mon_w.r3);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
        end
    end

    // pat 0: raster index; pat 1: extremes -128/127 mixed with index values.
    task automatic fill(input int pat);
        for (int i = 0; i < N; i++) begin
            if (pat == 0) begin
                img[i] = WI'(i);
            end else begin
                case (i % 3)
                    0:       img[i] = 8'h80;
                    1:       img[i] = 8'h7F;
                    default: img[i] = WI'(i);
                endcase
            end
        end
    endtask

    function automatic win_t expect_win(input int r, input int c);
        win_t w;
        w.r1 = {img[(r-2)*W + c-2], img[(r-2)*W + c-1], img[(r-2)*W + c]};
        w.r2 = {img[(r-1)*W + c-2], img[(r-1)*W + c-1], img[(r-1)*W + c]};
        w.r3 = {img[r*W + c-2],     img[r*W + c-1],     img[r*W + c]};
        return w;
    endfunction

    // Called on a negedge in IDLE. Returns on the negedge one cycle after the
    // last accepted pixel (limit pixels). start_at re-pulses iStart mid-frame.
    task automatic run_frame(input int start_at, input bit stall, input int limit);
        int idx;
        bit valid;
        idx   = 0;
        start = 1'b1;
        for (int k = 0; k < 400 && idx < limit; k++) begin
            @(negedge clk);
            start = (idx == start_at);
            valid = stall ? (k % 2 == 0) : 1'b1;
            pv    = valid;
            pd    = img[idx];
            if (valid && pix_ready === 1'b1) begin
                if (idx / W >= 2 && idx % W >= 2) begin
                    sb.push_back(expect_win(idx / W, idx % W));
                end
                idx++;
            end
        end
        @(negedge clk);
        pv    = 1'b0;
        start = 1'b0;
        check("pixels accepted", idx, limit);
    endtask

    // Entered at T+1 where T is the last-pixel accept cycle.
    task automatic finish_frame(input bit start_in_done);
        check("last win valid T+1", win_valid, 1'b1);
        check("done at T+1", done, 1'b0);
        @(negedge clk);
        check("done at T+2", done, 1'b0);
        check("busy at T+2", busy, 1'b1);
        @(negedge clk);
        check("done at T+3", done, 1'b1);
        check("busy at T+3", busy, 1'b1);
        start = start_in_done;
        @(negedge clk);
        start = 1'b0;
        check("done at T+4", done, 1'b0);
        check("busy at T+4", busy, 1'b0);
        check("ready at T+4", pix_ready, 1'b0);
        @(negedge clk);
        check("idle after DONE", busy, 1'b0);
        check("scoreboard drained", sb.size(), 0);
    endtask

    task automatic full_frame(input string tag, input int pat, input int start_at,
                              input bit stall, input bit start_in_done);
        int w0;
        fill(pat);
        w0 = win_cnt;
        run_frame(start_at, stall, N);
        finish_frame(start_in_done);
        check({tag, " window count"}, win_cnt - w0, (W-2)*(H-2));
    endtask

    initial begin
        int d0;
        int w0;
        rst   = 1'b1;
        start = 1'b0;
        pv    = 1'b0;
        pd    = '0;
        repeat (3) @(negedge clk);
        check("rst ready", pix_ready, 1'b0);
        check("rst win valid", win_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst rows", {win_row1, win_row2, win_row3} == '0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", busy, 1'b0);

        // Continuous raster frame, then the same frame with a 1/0 valid pattern.
        full_frame("raster", 0, -1, 1'b0, 1'b0);
        full_frame("stalled", 0, -1, 1'b1, 1'b0);

        // iStart during RUN and during DONE must be ignored.
        full_frame("start ignored", 0, 7, 1'b0, 1'b1);
        full_frame("fresh after ignore", 0, -1, 1'b0, 1'b0);

        // Reset after pixel 13 (two windows already emitted).
        fill(0);
        d0 = done_cnt;
        w0 = win_cnt;
        run_frame(-1, 1'b0, 14);
        rst = 1'b1;
        @(negedge clk);
        check("abort ready", pix_ready, 1'b0);
        check("abort win valid", win_valid, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort rows", {win_row1, win_row2, win_row3} == '0, 1'b1);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort no done", done_cnt, d0);
        check("abort windows", win_cnt - w0, 2);
        check("abort still idle", busy, 1'b0);
        full_frame("after abort", 0, -1, 1'b0, 1'b0);

        // Extreme signed values carried bit-exact.
        full_frame("extremes", 1, -1, 1'b0, 1'b0);
        full_frame("extremes stalled", 1, -1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
